// File: rtl/vsc8541_smi_ctrl.sv
// Clause-22 SMI (MDIO) frame engine for the VSC8541 management port.
// One request at a time; MDC is divided down from clk.
module vsc8541_smi_ctrl #(
  parameter int DIVISOR      = 100,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_rw,
  input  logic [4:0]  i_phy_addr,
  input  logic [4:0]  i_reg_addr,
  input  logic [15:0] i_wdata,
  input  logic        i_mdio_i,
  output logic        o_mdio_o,
  output logic        o_mdio_oe,
  output logic        o_mdc,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_rdata
);

  localparam int SW = $clog2(DIVISOR);
  localparam logic [SW-1:0] S_LAST = SW'(DIVISOR - 1);
  localparam logic [SW-1:0] S_HALF = SW'(DIVISOR / 2);
  localparam logic [5:0] PRE_LAST =
    6'(PREAMBLE_LEN > 0 ? PREAMBLE_LEN - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_DONE
  } state_t;

  state_t        state, state_d;
  logic [SW-1:0] sub;
  logic [5:0]    bcnt;
  logic [5:0]    last;
  logic [31:0]   sh;
  logic [15:0]   rx;
  logic          rw_q;
  logic          bit_end;

  always_comb begin
    bit_end = (sub == S_LAST);
    last    = 6'd0;
    state_d = state;
    unique case (state)
      S_PRE:   last = PRE_LAST;
      S_HDR:   last = 6'd13;
      S_TA:    last = 6'd1;
      S_DATA:  last = 6'd15;
      default: last = 6'd0;
    endcase
    unique case (state)
      S_IDLE:
        if (i_start)
          state_d = (PREAMBLE_LEN > 0) ? S_PRE : S_HDR;
      S_PRE:
        if (bit_end && bcnt == last) state_d = S_HDR;
      S_HDR:
        if (bit_end && bcnt == last) state_d = S_TA;
      S_TA:
        if (bit_end && bcnt == last) state_d = S_DATA;
      S_DATA:
        if (bit_end && bcnt == last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    o_busy = (state == S_PRE) || (state == S_HDR) ||
             (state == S_TA) || (state == S_DATA);
    o_done = (state == S_DONE);
    o_mdc  = o_busy && (sub >= S_HALF);
    // A read hands the line to the PHY from TA onwards.
    o_mdio_oe = (state == S_PRE) || (state == S_HDR) ||
                (((state == S_TA) || (state == S_DATA)) && !rw_q);
    o_mdio_o = 1'b1;
    if (o_mdio_oe && state != S_PRE) o_mdio_o = sh[31];
  end

  always_ff @(posedge clk) begin
    if (!i_reset) begin
      state   <= S_IDLE;
      sub     <= '0;
      bcnt    <= '0;
      sh      <= '0;
      rx      <= '0;
      rw_q    <= 1'b0;
      o_rdata <= '0;
    end else begin
      state <= state_d;
      if (state == S_IDLE) begin
        sub  <= '0;
        bcnt <= '0;
        if (i_start) begin
          rw_q <= i_rw;
          sh   <= {2'b01, i_rw ? 2'b10 : 2'b01,
                   i_phy_addr, i_reg_addr,
                   i_rw ? 2'b11 : 2'b10,
                   i_rw ? 16'hffff : i_wdata};
        end
      end else if (o_busy) begin
        if (bit_end) begin
          sub  <= '0;
          bcnt <= (state_d != state) ? 6'd0 : bcnt + 6'd1;
          if (state != S_PRE) sh <= {sh[30:0], 1'b1};
          if (state == S_DATA) begin
            rx <= {rx[14:0], i_mdio_i};
            if (rw_q && state_d == S_DONE)
              o_rdata <= {rx[14:0], i_mdio_i};
          end
        end else begin
          sub <= sub + 1'b1;
        end
      end
    end
  end

endmodule
